// File: rtl/alu_mul_seq_pkg.sv
// Shared constants for the sequential multiplier: ALU op selects, shift control
// and the controller state encoding.
package alu_mul_seq_pkg;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_XOR   = 3'b011;
  localparam logic [2:0] ALU_SLTU  = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [6:0] SLL_NONE  = 7'b0011111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-add multiplier that borrows the ALU adder, one
// partial product per cycle, with valid/ready request and response ports.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_WIDTH-1:0]   req_a,
  input  logic [DATA_WIDTH-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [2*DATA_WIDTH-1:0] resp_prod,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   alu_A,
  output logic [DATA_WIDTH-1:0]   alu_B,
  output logic [2:0]              alu_ALUcontrol,
  output logic [6:0]              alu_sll,
  input  logic [DATA_WIDTH-1:0]   alu_Result,
  input  logic                    alu_CarryOut
);

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            mcand_d = req_a;
            hi_d    = '0;
            lo_d    = req_b;
            cnt_d   = '0;
            // A zero operand makes the product zero; skip the iterations.
            if (req_a == '0 || req_b == '0) begin
              lo_d    = '0;
              state_d = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          // {CarryOut, Result, lo} shifted right by one becomes the new {hi, lo}.
          hi_d  = {alu_CarryOut, alu_Result[DATA_WIDTH-1:1]};
          lo_d  = {alu_Result[0], lo_q[DATA_WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIter) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_A          = '0;
    alu_B          = '0;
    alu_ALUcontrol = ALU_AND;
    alu_sll        = SLL_NONE;
    if (state_q == S_CALC) begin
      alu_A          = hi_q;
      alu_B          = lo_q[0] ? mcand_q : '0;
      alu_ALUcontrol = ALU_ADD;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_prod  = {hi_q, lo_q};

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomised and directed bench for alu_mul_seq; products are compared with
// plain 64-bit multiplication, with a behavioural ALU attached to the alu_* ports.
module tb_alu_mul_seq;
  import alu_mul_seq_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_prod;
  logic        busy;
  logic [31:0] alu_A, alu_B, alu_Result;
  logic [2:0]  alu_ALUcontrol;
  logic [6:0]  alu_sll;
  logic        alu_CarryOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.DATA_WIDTH(32), .CNT_W(6)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_prod      (resp_prod),
    .busy           (busy),
    .alu_A          (alu_A),
    .alu_B          (alu_B),
    .alu_ALUcontrol (alu_ALUcontrol),
    .alu_sll        (alu_sll),
    .alu_Result     (alu_Result),
    .alu_CarryOut   (alu_CarryOut)
  );

  // Behavioural stand-in for the parent's ALU.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case (alu_ALUcontrol)
      ALU_ADD: alu_sum = {1'b0, alu_A} + {1'b0, alu_B};
      ALU_AND: alu_sum = {1'b0, alu_A & alu_B};
      ALU_OR:  alu_sum = {1'b0, alu_A | alu_B};
      ALU_XOR: alu_sum = {1'b0, alu_A ^ alu_B};
      default: alu_sum = '0;
    endcase
  end
  assign alu_Result   = alu_sum[31:0];
  assign alu_CarryOut = alu_sum[32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One multiply: handshake, wait for the response, hold it for 'stall' cycles, take it.
  task automatic mul_txn(input logic [31:0] a, input logic [31:0] b, input int stall);
    int lat;
    int calc;
    logic [63:0] exp;
    exp = 64'(a) * 64'(b);
    @(negedge clk);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    resp_ready = 1'b0;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = $urandom;
    req_b = $urandom;
    lat = 1;
    calc = 0;
    while (!resp_valid && lat < 100) begin
      calc++;
      check("calc_aluctrl", 64'(alu_ALUcontrol), 64'(ALU_ADD));
      check("calc_sll", 64'(alu_sll), 64'(SLL_NONE));
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), (a == 0 || b == 0) ? 64'd1 : 64'd33);
    check("calc_cycles", 64'(calc), (a == 0 || b == 0) ? 64'd0 : 64'd32);
    check("product", resp_prod, exp);
    check("done_alu_idle", {alu_A, 22'd0, alu_ALUcontrol, alu_sll}, {32'd0, 22'd0, 3'b000, SLL_NONE});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_prod", resp_prod, exp);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("after_take_ready", 64'(req_ready), 64'd1);
    check("after_take_valid", 64'(resp_valid), 64'd0);
  endtask

  // Start a multiply and return after n CALC cycles have been observed.
  task automatic start_and_run(input logic [31:0] a, input logic [31:0] b, input int n);
    @(negedge clk);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    check("started_busy", 64'(busy), 64'd1);
    for (int i = 0; i < n - 1; i++) @(negedge clk);
  endtask

  initial begin
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_prod", resp_prod, 64'd0);
    #20 resetn = 1'b1;

    mul_txn(32'd3, 32'd5, 0);
    mul_txn(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    mul_txn(32'h80000000, 32'd2, 1);
    mul_txn(32'd0, 32'h1234, 0);
    mul_txn(32'd7, 32'd0, 0);
    mul_txn(32'd6, 32'd7, 5);

    // Flush in the middle of CALC.
    start_and_run(32'hDEADBEEF, 32'h12345678, 10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", 64'(busy), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (resp_valid) seen++;
        @(negedge clk);
      end
      check("flush_no_resp", 64'(seen), 64'd0);
    end
    mul_txn(32'd9, 32'd9, 0);

    // Flush wins over a simultaneous request.
    @(negedge clk);
    req_valid = 1'b1;
    req_a = 32'd5;
    req_b = 32'd5;
    flush = 1'b1;
    check("flush_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    check("flush_req_not_taken", 64'(busy), 64'd0);
    check("flush_req_ready_after", 64'(req_ready), 64'd1);

    // Asynchronous reset mid-operation.
    start_and_run(32'd12345, 32'd678, 20);
    #2 resetn = 1'b0;
    #1;
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd1);
    check("arst_prod", resp_prod, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    mul_txn(32'd12, 32'd12, 0);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 5) == 0) ra = 32'hFFFFFFFF;
      mul_txn(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
